// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the pipelined core's fetch path.
//   INSTR_W    : instruction word width
//   PC_INC     : byte distance between sequential instruction words
//   INSTR_NONE : value driven on the instruction bus when nothing is valid
// ---------------------------------------------------------------------------
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_INC = 4;
    localparam logic [INSTR_W-1:0] INSTR_NONE = 32'b0;
endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Circular buffer holding instruction words returned by memory until the
// fetch stage consumes them. The head is presented combinationally.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low
//   clear_i    : discard all contents (takes priority over push/pop)
//   push_i     : write pushData_i at the tail
//   pushData_i : word to write
//   pop_i      : drop the head entry
//   count_o    : number of valid entries
//   empty_o    : no valid entries
//   head_o     : oldest entry (meaningless when empty)
// ---------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] pushData_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic [INSTR_W-1:0] head_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    generate
        if (DEPTH == 1) begin : gSingle
            logic [INSTR_W-1:0] data_q;

            // A single-entry buffer needs no pointers; the one slot is the head.
            always_ff @(posedge clk) begin
                if (push_i) begin
                    data_q <= pushData_i;
                end
            end

            assign head_o = data_q;
        end else begin : gRing
            localparam int PTR_W = $clog2(DEPTH);
            localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

            logic [INSTR_W-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0]   rdPtr_q, wrPtr_q;

            // Storage is never read while empty, so it carries no reset.
            always_ff @(posedge clk) begin
                if (push_i) begin
                    mem_q[wrPtr_q] <= pushData_i;
                end
            end

            // Read/write pointers wrap explicitly so any depth works.
            always_ff @(posedge clk) begin
                if (!reset || clear_i) begin
                    rdPtr_q <= '0;
                    wrPtr_q <= '0;
                end else begin
                    if (push_i) begin
                        wrPtr_q <= (wrPtr_q == LAST) ? '0 : wrPtr_q + PTR_W'(1);
                    end
                    if (pop_i) begin
                        rdPtr_q <= (rdPtr_q == LAST) ? '0 : rdPtr_q + PTR_W'(1);
                    end
                end
            end

            assign head_o = mem_q[rdPtr_q];
        end
    endgenerate

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch queue between the instruction memory port and the
// fetch stage. Issues in-order sequential word requests, buffers returned
// words and presents the word at PCF with a valid flag. A PCF that leaves the
// expected sequential stream flushes the buffer and turns every in-flight
// response into one that is silently discarded on arrival.
// Configuration macro FETCH_PREFETCH_EN:
//   defined     : up to DEPTH words buffered plus outstanding
//   not defined : demand fetch, one word buffered or outstanding at a time
// Ports:
//   clk, reset  : clock and synchronous active-low reset
//   PCF, StallF : fetch address and fetch stall from the pipeline
//   InstrF      : word at PCF, zero when not valid
//   InstrValidF : InstrF holds the word at PCF
//   IMissF      : inverse of InstrValidF, stall request to the hazard unit
//   imem_req, imem_addr, imem_gnt : request handshake to instruction memory
//   imem_rvalid, imem_rdata       : in-order responses, one per grant
// ---------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  PCF,
    input  logic               StallF,
    output logic [INSTR_W-1:0] InstrF,
    output logic               InstrValidF,
    output logic               IMissF,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata
);

`ifdef FETCH_PREFETCH_EN
    localparam int LIMIT = DEPTH;
`else
    localparam int LIMIT = 1;
`endif
    localparam int FIFO_CW = $clog2(LIMIT) + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 2;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]  expAddr_q, expAddr_d;
    logic [ADDR_W-1:0]  nextAddr_q, nextAddr_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [FIFO_CW-1:0] fifoCount;
    logic               fifoEmpty;
    logic [INSTR_W-1:0] fifoHead;
    logic [CNT_W-1:0]   occupancy;
    logic               redirect, grant, dropResp, push, hit, pop;

    // A PC that is not the word we expected to hand out next means the
    // pipeline branched; buffered words count as gone in this very cycle so
    // the new target can be requested immediately.
    assign redirect  = (PCF != expAddr_q);
    assign occupancy = (redirect ? '0 : CNT_W'(fifoCount)) + inflight_q + drop_q;

    // Requests are held off during reset so the memory sees a quiet bus.
    assign imem_req  = reset && (occupancy < CNT_W'(LIMIT));
    assign imem_addr = redirect ? PCF : nextAddr_q;
    assign grant     = imem_req && imem_gnt;

    // Stale responses are consumed first because responses return in order.
    assign dropResp  = imem_rvalid && (drop_q != '0);
    assign push      = imem_rvalid && !dropResp && !redirect;

    assign hit         = reset && !redirect && !fifoEmpty;
    assign pop         = hit && !StallF;
    assign InstrValidF = hit;
    assign IMissF      = !hit;
    assign InstrF      = hit ? fifoHead : INSTR_NONE;

    // Counter and address update. On a redirect every live request becomes
    // stale (a response arriving now is one of them), and only a request
    // granted this cycle for the new target is live.
    always_comb begin
        inflight_d = inflight_q;
        drop_d     = drop_q;
        expAddr_d  = expAddr_q;
        nextAddr_d = nextAddr_q;
        if (redirect) begin
            drop_d     = drop_q + inflight_q - CNT_W'(imem_rvalid);
            inflight_d = CNT_W'(grant);
            expAddr_d  = PCF;
            nextAddr_d = grant ? PCF + INC : PCF;
        end else begin
            if (dropResp) begin
                drop_d = drop_q - CNT_W'(1);
            end
            inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(push);
            if (pop) begin
                expAddr_d = expAddr_q + INC;
            end
            if (grant) begin
                nextAddr_d = nextAddr_q + INC;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            expAddr_q  <= '0;
            nextAddr_q <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            expAddr_q  <= expAddr_d;
            nextAddr_q <= nextAddr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (LIMIT),
        .CNT_W (FIFO_CW)
    ) uFifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (redirect),
        .push_i     (push),
        .pushData_i (imem_rdata),
        .pop_i      (pop),
        .count_o    (fifoCount),
        .empty_o    (fifoEmpty),
        .head_o     (fifoHead)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Drives fetch_queue with a variable-latency instruction memory and a simple
// fetch stage, and compares every cycle against a queue-based model of the
// prefetch rules. Works with and without FETCH_PREFETCH_EN.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_PREFETCH_EN
    localparam int LIMIT = DEPTH;
    localparam logic [5:0] EXP_VALID_PATTERN = 6'b111100;
`else
    localparam int LIMIT = 1;
    localparam logic [5:0] EXP_VALID_PATTERN = 6'b100100;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PCF = 32'h0;
    logic        StallF = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        IMissF;
    logic        imem_req;
    logic [31:0] imem_addr;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .StallF      (StallF),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .IMissF      (IMissF),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    int          latency = 1;
    int          gntMode = 0;
    int          cycle = 0;

    logic [31:0] mBuf[$];
    int          mInflight = 0;
    int          mDrop = 0;
    logic [31:0] mExp = 32'h0;
    logic [31:0] mNext = 32'h0;

    int          testsRun = 0;
    int          testsFailed = 0;

    logic        sValid, sReq, sMiss, sGrant;
    logic [31:0] sInstr, sAddr;

    // Memory contents: every word is derived from its own address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, required);
        end
    endtask

    // One clock cycle: sample and compare at the falling edge, advance the
    // model and the memory, then drive the memory side for the next cycle.
    task automatic applyStimulus();
        logic        redirect, expReq, expValid, g;
        logic [31:0] expAddrOut, expInstr;
        int          occ;
        @(negedge clk);
        sValid = InstrValidF;
        sInstr = InstrF;
        sMiss  = IMissF;
        sReq   = imem_req;
        sAddr  = imem_addr;
        sGrant = imem_req && imem_gnt;
        if (!reset) begin
            checkOutput("reset_req", imem_req, 0);
            checkOutput("reset_valid", InstrValidF, 0);
            checkOutput("reset_instr", InstrF, 0);
            checkOutput("reset_imiss", IMissF, 1);
            mBuf.delete();
            mInflight = 0;
            mDrop = 0;
            mExp = 32'h0;
            mNext = 32'h0;
        end else begin
            redirect   = (PCF != mExp);
            occ        = (redirect ? 0 : mBuf.size()) + mInflight + mDrop;
            expReq     = (occ < LIMIT);
            expAddrOut = redirect ? PCF : mNext;
            expValid   = !redirect && (mBuf.size() > 0);
            expInstr   = expValid ? mBuf[0] : 32'h0;
            checkOutput("imem_req", imem_req, expReq);
            if (expReq) checkOutput("imem_addr", imem_addr, expAddrOut);
            checkOutput("valid", InstrValidF, expValid);
            checkOutput("instr", InstrF, expInstr);
            checkOutput("imiss", IMissF, !expValid);
            if (InstrValidF) checkOutput("instr_at_pc", InstrF, memWord(PCF));
            g = expReq && imem_gnt;
            if (redirect) begin
                mBuf.delete();
                mDrop = mDrop + mInflight - (imem_rvalid ? 1 : 0);
                mInflight = g ? 1 : 0;
                mExp = PCF;
                mNext = g ? PCF + 32'd4 : PCF;
            end else begin
                if (expValid && !StallF) begin
                    void'(mBuf.pop_front());
                    mExp = mExp + 32'd4;
                end
                if (imem_rvalid) begin
                    if (mDrop > 0) begin
                        mDrop--;
                    end else begin
                        mBuf.push_back(imem_rdata);
                        mInflight--;
                    end
                end
                if (g) begin
                    mInflight++;
                    mNext = mNext + 32'd4;
                end
            end
        end
        if (reset && imem_req && imem_gnt) memQ.push_back('{imem_addr, cycle + latency});
        checkOutput("outstanding_bound", (memQ.size() > LIMIT) ? 1 : 0, 0);
        @(posedge clk);
        #1;
        cycle++;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!reset) begin
            memQ.delete();
        end else if (memQ.size() > 0 && memQ[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end
        case (gntMode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = ~imem_gnt;
            default: imem_gnt = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    // The fetch stage moves on only when it got its word and is not stalled.
    task automatic advancePc();
        if (sValid && !StallF) PCF = PCF + 32'd4;
    endtask

    task automatic waitValid(input int maxCycles);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxCycles && !ok; i++) begin
            applyStimulus();
            if (sValid) ok = 1;
        end
        checkOutput("valid_within_bound", ok, 1);
    endtask

    initial begin
        logic [5:0]  validHist;
        logic [31:0] grantAddrs[$];
        logic [31:0] instrCycle2;

        // Reset and sequential start from address 0 with 1-cycle memory.
        reset = 1'b0;
        repeat (3) applyStimulus();
        reset = 1'b1;
        validHist = '0;
        instrCycle2 = '0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (i < 6) validHist[i] = sValid;
            if (i == 2) instrCycle2 = sInstr;
            if (sGrant) grantAddrs.push_back(sAddr);
            advancePc();
        end
        checkOutput("valid_pattern", validHist, EXP_VALID_PATTERN);
        checkOutput("first_instr", instrCycle2, 32'h0000FFFF);
        checkOutput("grant_count_ge4", (grantAddrs.size() >= 4) ? 1 : 0, 1);
        if (grantAddrs.size() >= 4) begin
            checkOutput("req_addr0", grantAddrs[0], 32'h0);
            checkOutput("req_addr1", grantAddrs[1], 32'h4);
            checkOutput("req_addr2", grantAddrs[2], 32'h8);
            checkOutput("req_addr3", grantAddrs[3], 32'hC);
        end

        // Stall with PCF held at 0x8, then reset with words buffered.
        reset = 1'b0;
        PCF = 32'h0;
        repeat (2) applyStimulus();
        reset = 1'b1;
        for (int i = 0; i < 30 && PCF != 32'h8; i++) begin
            applyStimulus();
            advancePc();
        end
        checkOutput("reach_pc_8", PCF, 32'h8);
        StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            if (sValid) checkOutput("stall_instr", sInstr, 32'h0008FFF7);
        end
        checkOutput("stall_valid_end", sValid, 1);
        checkOutput("stall_req_full", sReq, 0);
        reset = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("rst_mid_valid", sValid, 0);
        checkOutput("rst_mid_req", sReq, 0);
        checkOutput("rst_mid_imiss", sMiss, 1);
        reset = 1'b1;
        PCF = 32'h0;
        StallF = 1'b0;
        applyStimulus();
        checkOutput("post_rst_req", sReq, 1);
        checkOutput("post_rst_addr", sAddr, 32'h0);
        advancePc();
        applyStimulus();
        advancePc();
        applyStimulus();
        checkOutput("post_rst_valid", sValid, 1);
        checkOutput("post_rst_instr", sInstr, 32'h0000FFFF);
        advancePc();

        // Redirect 0xC -> 0x100 with 3-cycle memory so responses are in flight.
        latency = 3;
        for (int i = 0; i < 40 && PCF != 32'hC; i++) begin
            applyStimulus();
            advancePc();
        end
        checkOutput("reach_pc_c", PCF, 32'hC);
        PCF = 32'h100;
        applyStimulus();
        checkOutput("redirect_addr", sAddr, 32'h100);
        if (!sValid) waitValid(30);
        checkOutput("redirect_instr", sInstr, 32'h0100FEFF);
        advancePc();

        // Latency 3 with grant toggling every other cycle.
        gntMode = 1;
        for (int i = 0; i < 60; i++) begin
            StallF = ($urandom_range(0, 3) == 0);
            applyStimulus();
            advancePc();
        end

        // Randomised traffic: latency, grants, stalls, redirects, resets.
        gntMode = 2;
        for (int i = 0; i < 3000; i++) begin
            latency = $urandom_range(1, 4);
            StallF = ($urandom_range(0, 3) == 0);
            applyStimulus();
            advancePc();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    PCF = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                else
                    PCF = $urandom & 32'hFFFF_FFFC;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
